// File: rtl/rover_pio_pkg.sv
// Shared definitions for the rover PIO blocks.
//   pio_addr_e : Avalon word addresses of the PIO register map
//   EDGE_*     : values of the EDGE_TYPE parameter (which transitions are captured)
package rover_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA = 2'd0,  // RO  debounced input levels
    PIO_ADDR_RSVD = 2'd1,  // reads 0, writes ignored
    PIO_ADDR_MASK = 2'd2,  // RW  interrupt mask
    PIO_ADDR_EDGE = 2'd3   // edge capture, write-1-to-clear
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/rover_pio_in_capture_if.sv
// Avalon-MM slave bus of the rover input PIO.
//   address    : word address (see pio_addr_e)
//   chipselect : slave select
//   read_n     : read strobe, active low
//   write_n    : write strobe, active low
//   writedata  : write data
//   readdata   : registered read data, read latency 1
// master drives the request, slave returns readdata.
interface rover_pio_in_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/rover_pio_debounce.sv
// Single-bit debouncer for an already-synchronised input.
//   clk, reset_n : clock and asynchronous active-low reset
//   d_sync       : synchronised input
//   q            : debounced output; follows d_sync only after CYCLES
//                  consecutive cycles of disagreement
// CYCLES must be >= 1; the zero (bypass) case is handled by the instantiator.
module rover_pio_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_sync,
  output logic q
);

  localparam int              CW       = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d_sync == q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      // Input disagreed for CYCLES consecutive cycles: accept it.
      q   <= d_sync;
      cnt <= '0;
    end else if (cnt != '1) begin
      // Saturate rather than wrap so a stuck count can never alias to CNT_LAST.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rover_pio_in_capture.sv
// Avalon-MM input PIO: synchronises (and optionally debounces) external
// status lines, latches selected edges and raises a maskable level irq.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (DATA / RSVD / MASK / EDGE registers)
//   in_port      : asynchronous external inputs
//   irq          : |(edge_capture & irq_mask)
// A line already high at reset release is seen as a rising edge once
// (prev and debounced start at 0); software clears EDGE after init.
module rover_pio_in_capture
  import rover_pio_pkg::*;
#(
  parameter int          WIDTH           = 8,
  parameter int          EDGE_TYPE       = EDGE_RISE,
  parameter int          DEBOUNCE_CYCLES = 0,
  parameter logic [31:0] RESET_MASK      = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rover_pio_in_capture_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync1, sync2, debounced, prev;
  logic [WIDTH-1:0] edge_det, w1c, edge_capture, irq_mask;
  logic [31:0]      rd_mux;
  logic             wr_en, rd_en;

  // Debounce stage: a plain wire when bypassed, otherwise one counter per bit.
  if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
    assign debounced = sync2;
  end else begin : g_deb
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      rover_pio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .d_sync (sync2[i]),
        .q      (debounced[i])
      );
    end
  end

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;
  assign w1c   = (wr_en && bus.address == PIO_ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = debounced & ~prev;
      EDGE_FALL: edge_det = ~debounced & prev;
      default:   edge_det = debounced ^ prev;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      PIO_ADDR_DATA: rd_mux[WIDTH-1:0] = debounced;
      PIO_ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      edge_capture <= '0;
      irq_mask     <= RESET_MASK[WIDTH-1:0];
      bus.readdata <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= debounced;
      // A new edge beats a simultaneous clear so no event is ever lost.
      edge_capture <= edge_det | (edge_capture & ~w1c);
      if (wr_en && bus.address == PIO_ADDR_MASK) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      if (rd_en) begin
        bus.readdata <= rd_mux;
      end
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_rover_pio_in_capture.sv
// Self-checking bench for rover_pio_in_capture. Four instances share one
// Avalon bus (writes reach all of them) and each has its own in_port:
//   0: rise, no debounce, RESET_MASK 0x81    1: rise, debounce 4
//   2: any edge, no debounce                 3: fall, no debounce
module tb_rover_pio_in_capture;
  import rover_pio_pkg::*;

  typedef struct {
    logic [7:0] in_val;
    logic [7:0] exp_data;
    logic [7:0] exp_edge;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_p [4];
  logic        irq_v [4];
  logic [31:0] rdata [4];

  int n_tests = 0;
  int n_fail  = 0;
  rd_exp_t sb[$];
  vec_t    vecs[7];

  always #5 clk = ~clk;

  rover_pio_in_capture_if if_a ();
  rover_pio_in_capture_if if_b ();
  rover_pio_in_capture_if if_c ();
  rover_pio_in_capture_if if_d ();

  assign if_a.address = address;  assign if_a.chipselect = chipselect;
  assign if_a.read_n  = read_n;   assign if_a.write_n    = write_n;
  assign if_a.writedata = writedata;
  assign if_b.address = address;  assign if_b.chipselect = chipselect;
  assign if_b.read_n  = read_n;   assign if_b.write_n    = write_n;
  assign if_b.writedata = writedata;
  assign if_c.address = address;  assign if_c.chipselect = chipselect;
  assign if_c.read_n  = read_n;   assign if_c.write_n    = write_n;
  assign if_c.writedata = writedata;
  assign if_d.address = address;  assign if_d.chipselect = chipselect;
  assign if_d.read_n  = read_n;   assign if_d.write_n    = write_n;
  assign if_d.writedata = writedata;

  assign rdata[0] = if_a.readdata;
  assign rdata[1] = if_b.readdata;
  assign rdata[2] = if_c.readdata;
  assign rdata[3] = if_d.readdata;

  rover_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_RISE), .DEBOUNCE_CYCLES(0),
                         .RESET_MASK(32'h81)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a), .in_port(in_p[0]), .irq(irq_v[0]));
  rover_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_RISE), .DEBOUNCE_CYCLES(4),
                         .RESET_MASK(32'h0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b), .in_port(in_p[1]), .irq(irq_v[1]));
  rover_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(0),
                         .RESET_MASK(32'h0)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c), .in_port(in_p[2]), .irq(irq_v[2]));
  rover_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_FALL), .DEBOUNCE_CYCLES(0),
                         .RESET_MASK(32'h0)) dut_d (
    .clk(clk), .reset_n(reset_n), .bus(if_d), .in_port(in_p[3]), .irq(irq_v[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Read: expectation queued when the request is driven, compared once the
  // registered readdata appears one clock later.
  task automatic rd(input int id, input logic [1:0] a, input logic [31:0] exp,
                    input string name);
    rd_exp_t e;
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    e.id = id; e.exp = exp; e.name = name;
    sb.push_back(e);
    cyc();
    chipselect = 1'b0;
    read_n     = 1'b1;
    e = sb.pop_front();
    check(e.name, rdata[e.id], e.exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [7:0] mask_m;

    vecs[0] = '{in_val: 8'h05, exp_data: 8'h05, exp_edge: 8'h05};
    vecs[1] = '{in_val: 8'h0F, exp_data: 8'h0F, exp_edge: 8'h0A};
    vecs[2] = '{in_val: 8'h00, exp_data: 8'h00, exp_edge: 8'h00};
    vecs[3] = '{in_val: 8'hA5, exp_data: 8'hA5, exp_edge: 8'hA5};
    vecs[4] = '{in_val: 8'h5A, exp_data: 8'h5A, exp_edge: 8'h5A};
    vecs[5] = '{in_val: 8'hFF, exp_data: 8'hFF, exp_edge: 8'hA5};
    vecs[6] = '{in_val: 8'h80, exp_data: 8'h80, exp_edge: 8'h00};
    mask_m = 8'h81;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = '0;
    for (int i = 0; i < 4; i++) in_p[i] = 8'h00;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // Post-reset register state.
    check("reset irq", 32'(irq_v[0]), 32'h0);
    rd(0, PIO_ADDR_MASK, 32'h81, "reset mask");
    rd(0, PIO_ADDR_EDGE, 32'h0,  "reset edge");
    rd(0, PIO_ADDR_DATA, 32'h0,  "reset data");

    // Table: rising-edge capture, DATA and irq against the reset mask.
    for (int i = 0; i < 7; i++) begin
      in_p[0] = vecs[i].in_val;
      repeat (3) cyc();
      check($sformatf("vec%0d irq", i), 32'(irq_v[0]), 32'(|(vecs[i].exp_edge & mask_m)));
      rd(0, PIO_ADDR_DATA, 32'(vecs[i].exp_data), $sformatf("vec%0d data", i));
      rd(0, PIO_ADDR_EDGE, 32'(vecs[i].exp_edge), $sformatf("vec%0d edge", i));
      wr(PIO_ADDR_EDGE, 32'hFF);
    end

    // DATA read-only, RSVD reads zero, read latency and readdata hold.
    wr(PIO_ADDR_DATA, 32'hFFFF_FFFF);
    rd(0, PIO_ADDR_DATA, 32'h80, "data ignores write");
    wr(PIO_ADDR_RSVD, 32'hFFFF_FFFF);
    rd(0, PIO_ADDR_RSVD, 32'h0, "rsvd reads zero");
    in_p[0] = 8'hA5;
    repeat (3) cyc();
    rd(0, PIO_ADDR_DATA, 32'h0000_00A5, "read latency");
    in_p[0] = 8'h00;
    repeat (3) cyc();
    check("readdata hold", rdata[0], 32'h0000_00A5);
    wr(PIO_ADDR_EDGE, 32'hFF);

    // Mask, W1C and irq timing.
    wr(PIO_ADDR_MASK, 32'hFFFF_FF04);
    rd(0, PIO_ADDR_MASK, 32'h04, "mask upper bits ignored");
    in_p[0] = 8'h05;
    repeat (3) cyc();
    check("irq masked edge", 32'(irq_v[0]), 32'h1);
    rd(0, PIO_ADDR_EDGE, 32'h05, "edge 0x05");
    wr(PIO_ADDR_EDGE, 32'h04);
    check("irq after w1c", 32'(irq_v[0]), 32'h0);
    rd(0, PIO_ADDR_EDGE, 32'h01, "edge after w1c");
    wr(PIO_ADDR_MASK, 32'h01);
    check("irq on unmask", 32'(irq_v[0]), 32'h1);
    wr(PIO_ADDR_MASK, 32'h00);
    check("irq masked off", 32'(irq_v[0]), 32'h0);
    rd(0, PIO_ADDR_EDGE, 32'h01, "mask keeps edge");
    wr(PIO_ADDR_EDGE, 32'hFF);

    // Rising edge on bit1 lands in the same cycle as a W1C of bit1.
    in_p[0] = 8'h07;
    cyc();
    cyc();
    wr(PIO_ADDR_EDGE, 32'h02);
    rd(0, PIO_ADDR_EDGE, 32'h02, "collision set wins");

    // Reset mid-run with a pending, unmasked capture and non-zero readdata.
    wr(PIO_ADDR_MASK, 32'h02);
    check("irq before reset", 32'(irq_v[0]), 32'h1);
    in_p[0] = 8'h00;
    repeat (3) cyc();
    rd(0, PIO_ADDR_EDGE, 32'h02, "edge before reset");
    reset_n = 1'b0;
    #1;
    check("readdata in reset", rdata[0], 32'h0);
    check("irq in reset", 32'(irq_v[0]), 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    rd(0, PIO_ADDR_MASK, 32'h81, "mask after reset");
    rd(0, PIO_ADDR_EDGE, 32'h0,  "edge after reset");
    check("irq after reset", 32'(irq_v[0]), 32'h0);

    // Debounce: a 3-cycle glitch is rejected, a long pulse is accepted.
    in_p[1] = 8'h01;
    repeat (3) cyc();
    in_p[1] = 8'h00;
    repeat (8) cyc();
    rd(1, PIO_ADDR_DATA, 32'h0, "deb glitch data");
    rd(1, PIO_ADDR_EDGE, 32'h0, "deb glitch edge");
    in_p[1] = 8'h01;
    repeat (6) cyc();
    rd(1, PIO_ADDR_DATA, 32'h1, "deb pulse data");
    in_p[1] = 8'h00;
    rd(1, PIO_ADDR_EDGE, 32'h1, "deb pulse edge");
    repeat (10) cyc();
    rd(1, PIO_ADDR_DATA, 32'h0, "deb release data");
    rd(1, PIO_ADDR_EDGE, 32'h1, "deb rise only");

    // Any-edge and falling-edge capture on bit3, W1C between.
    wr(PIO_ADDR_EDGE, 32'hFF);
    in_p[2] = 8'h08;
    in_p[3] = 8'h08;
    repeat (3) cyc();
    rd(2, PIO_ADDR_EDGE, 32'h08, "any rise");
    rd(3, PIO_ADDR_EDGE, 32'h00, "fall ignores rise");
    wr(PIO_ADDR_EDGE, 32'h08);
    in_p[2] = 8'h00;
    in_p[3] = 8'h00;
    repeat (3) cyc();
    rd(2, PIO_ADDR_EDGE, 32'h08, "any fall");
    rd(3, PIO_ADDR_EDGE, 32'h08, "fall capture");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
